// File: rtl/plot_arbiter.sv
// Round-robin pixel-write arbiter with burst locking in front of vga_adapter.
// Optional macro PLOT_ARB_BOUNDS_EN drops off-screen pixels and adds drop_count.
module plot_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                CLK50,
  input  logic                reset,
  input  logic                hold,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [8*NREQ-1:0]   req_x,
  input  logic [7*NREQ-1:0]   req_y,
  input  logic [3*NREQ-1:0]   req_colour,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_plot,
  output logic [2:0]          owner,
  output logic                locked,
  output logic [CNT_W-1:0]    pix_count
`ifdef PLOT_ARB_BOUNDS_EN
  ,
  output logic [7:0]          drop_count
`endif
);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t           r_state, w_state_nx;
  logic [2:0]       r_owner, w_owner_nx;
  logic [2:0]       r_last;
  logic [2:0]       w_gidx;
  logic             w_grant;
  logic             w_gnt_lock;
  logic             w_own_req, w_own_lock;
  logic [NREQ-1:0]  w_gnt;
  logic [7:0]       w_sel_x;
  logic [6:0]       w_sel_y;
  logic [2:0]       w_sel_c;
  logic [7:0]       r_x;
  logic [6:0]       r_y;
  logic [2:0]       r_c;
  logic             r_plot;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_own_req  = req[i];
        w_own_lock = lock[i];
      end
    end
  end

  // Next-state and grant decision
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_grant    = 1'b0;
    w_gidx     = r_owner;
    w_gnt_lock = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (!hold) begin
          // Descending distance so the nearest requester after last writes last and wins.
          for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
              if ((i == (int'(r_last) + k) % NREQ) && req[i]) begin
                w_grant    = 1'b1;
                w_gidx     = 3'(i);
                w_gnt_lock = lock[i];
              end
            end
          end
        end
        if (w_grant && w_gnt_lock) begin
          w_state_nx = ST_LOCK;
          w_owner_nx = w_gidx;
        end
      end
      ST_LOCK: begin
        if (!w_own_req) begin
          w_state_nx = ST_ARB;
        end else if (!hold) begin
          w_grant = 1'b1;
          w_gidx  = r_owner;
          if (!w_own_lock) w_state_nx = ST_ARB;
        end
      end
      default: w_state_nx = ST_ARB;
    endcase
    if (reset) w_grant = 1'b0;
  end

  always_comb begin
    w_gnt   = '0;
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt[i] = w_grant && (w_gidx == 3'(i));
      if (w_gidx == 3'(i)) begin
        w_sel_x = req_x[8*i +: 8];
        w_sel_y = req_y[7*i +: 7];
        w_sel_c = req_colour[3*i +: 3];
      end
    end
  end

`ifdef PLOT_ARB_BOUNDS_EN
  logic       w_inb;
  logic [7:0] r_drop;
  assign w_inb = (w_sel_x <= 8'd159) && (w_sel_y <= 7'd119);
`endif

  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_owner <= 3'd0;
      r_last  <= 3'(NREQ - 1);
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      if (w_grant) r_last <= w_gidx;
    end
  end

  // Output register stage toward the adapter
  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
      r_plot <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      if (w_grant) begin
`ifdef PLOT_ARB_BOUNDS_EN
        if (w_inb) begin
          r_x    <= w_sel_x;
          r_y    <= w_sel_y;
          r_c    <= w_sel_c;
          r_plot <= 1'b1;
        end
`else
        r_x    <= w_sel_x;
        r_y    <= w_sel_y;
        r_c    <= w_sel_c;
        r_plot <= 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_plot && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef PLOT_ARB_BOUNDS_EN
  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_grant && !w_inb && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 1'b1;
    end
  end
  assign drop_count = r_drop;
`endif

  assign gnt        = w_gnt;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_c;
  assign vga_plot   = r_plot;
  assign owner      = r_owner;
  assign locked     = (r_state == ST_LOCK);
  assign pix_count  = r_cnt;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed table-driven bench for plot_arbiter (NREQ=3, narrow counter to reach saturation).
module tb_plot_arbiter;

  localparam int NREQ  = 3;
  localparam int CNT_W = 5;

  logic              CLK50, reset, hold;
  logic [NREQ-1:0]   req, lock;
  logic [8*NREQ-1:0] req_x;
  logic [7*NREQ-1:0] req_y;
  logic [3*NREQ-1:0] req_colour;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              vga_plot;
  logic [2:0]        owner;
  logic              locked;
  logic [CNT_W-1:0]  pix_count;
`ifdef PLOT_ARB_BOUNDS_EN
  logic [7:0]        drop_count;
`endif

  plot_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .CLK50(CLK50), .reset(reset), .hold(hold), .req(req), .lock(lock),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .gnt(gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .owner(owner), .locked(locked), .pix_count(pix_count)
`ifdef PLOT_ARB_BOUNDS_EN
    , .drop_count(drop_count)
`endif
  );

  initial CLK50 = 1'b0;
  always #5 CLK50 = ~CLK50;

  typedef struct {
    logic       rst, hld;
    logic [2:0] rq, lk;
    logic [2:0] e_gnt;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    logic       e_lk;
    logic [2:0] e_own;
    logic [4:0] e_cnt;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl[NV];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic hld, input logic [2:0] rq,
                              input logic [2:0] lk, input logic [2:0] g, input logic p,
                              input int x, input int y, input int c, input logic l,
                              input int o, input int n);
    vec_t v;
    v.rst = rst; v.hld = hld; v.rq = rq; v.lk = lk; v.e_gnt = g; v.e_plot = p;
    v.e_x = 8'(x); v.e_y = 7'(y); v.e_c = 3'(c); v.e_lk = l; v.e_own = 3'(o);
    v.e_cnt = 5'(n);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // requester 0: (10,20,1), 1: (40,30,5), 2: (12,22,3)
    req_x      = {8'd12, 8'd40, 8'd10};
    req_y      = {7'd22, 7'd30, 7'd20};
    req_colour = {3'd3, 3'd5, 3'd1};
    reset = 1'b1; hold = 1'b0; req = '0; lock = '0;

    tbl[0]  = mk(1,0,3'b000,3'b000, 3'b000,0,  0, 0,0, 0,0, 0);
    tbl[1]  = mk(0,0,3'b010,3'b000, 3'b010,0,  0, 0,0, 0,0, 0);
    tbl[2]  = mk(0,0,3'b000,3'b000, 3'b000,1, 40,30,5, 0,0, 0);
    tbl[3]  = mk(0,0,3'b000,3'b000, 3'b000,0, 40,30,5, 0,0, 1);
    tbl[4]  = mk(1,0,3'b000,3'b000, 3'b000,0,  0, 0,0, 0,0, 0);
    tbl[5]  = mk(0,0,3'b111,3'b000, 3'b001,0,  0, 0,0, 0,0, 0);
    tbl[6]  = mk(0,0,3'b111,3'b000, 3'b010,1, 10,20,1, 0,0, 0);
    tbl[7]  = mk(0,0,3'b111,3'b000, 3'b100,1, 40,30,5, 0,0, 1);
    tbl[8]  = mk(0,0,3'b111,3'b000, 3'b001,1, 12,22,3, 0,0, 2);
    tbl[9]  = mk(0,0,3'b111,3'b000, 3'b010,1, 10,20,1, 0,0, 3);
    tbl[10] = mk(0,0,3'b111,3'b000, 3'b100,1, 40,30,5, 0,0, 4);
    tbl[11] = mk(0,0,3'b000,3'b000, 3'b000,1, 12,22,3, 0,0, 5);
    tbl[12] = mk(0,0,3'b000,3'b000, 3'b000,0, 12,22,3, 0,0, 6);
    tbl[13] = mk(0,0,3'b101,3'b001, 3'b001,0, 12,22,3, 0,0, 6);
    tbl[14] = mk(0,0,3'b101,3'b001, 3'b001,1, 10,20,1, 1,0, 6);
    tbl[15] = mk(0,0,3'b101,3'b001, 3'b001,1, 10,20,1, 1,0, 7);
    tbl[16] = mk(0,0,3'b101,3'b001, 3'b001,1, 10,20,1, 1,0, 8);
    tbl[17] = mk(0,0,3'b101,3'b000, 3'b001,1, 10,20,1, 1,0, 9);
    tbl[18] = mk(0,0,3'b100,3'b000, 3'b100,1, 10,20,1, 0,0,10);
    tbl[19] = mk(0,0,3'b000,3'b000, 3'b000,1, 12,22,3, 0,0,11);
    tbl[20] = mk(0,0,3'b000,3'b000, 3'b000,0, 12,22,3, 0,0,12);
    tbl[21] = mk(0,1,3'b011,3'b000, 3'b000,0, 12,22,3, 0,0,12);
    tbl[22] = mk(0,1,3'b011,3'b000, 3'b000,0, 12,22,3, 0,0,12);
    tbl[23] = mk(0,1,3'b011,3'b000, 3'b000,0, 12,22,3, 0,0,12);
    tbl[24] = mk(0,0,3'b011,3'b000, 3'b001,0, 12,22,3, 0,0,12);
    tbl[25] = mk(0,0,3'b000,3'b000, 3'b000,1, 10,20,1, 0,0,12);
    tbl[26] = mk(0,0,3'b000,3'b000, 3'b000,0, 10,20,1, 0,0,13);
    tbl[27] = mk(0,0,3'b010,3'b010, 3'b010,0, 10,20,1, 0,0,13);
    tbl[28] = mk(0,1,3'b010,3'b010, 3'b000,1, 40,30,5, 1,1,13);
    tbl[29] = mk(0,0,3'b010,3'b010, 3'b010,0, 40,30,5, 1,1,14);
    tbl[30] = mk(0,0,3'b000,3'b000, 3'b000,1, 40,30,5, 1,1,14);
    tbl[31] = mk(0,0,3'b001,3'b000, 3'b001,0, 40,30,5, 0,1,15);
    tbl[32] = mk(0,0,3'b000,3'b000, 3'b000,1, 10,20,1, 0,1,15);
    tbl[33] = mk(0,0,3'b010,3'b010, 3'b010,0, 10,20,1, 0,1,16);
    tbl[34] = mk(0,0,3'b010,3'b010, 3'b010,1, 40,30,5, 1,1,16);
    tbl[35] = mk(1,0,3'b010,3'b010, 3'b000,0,  0, 0,0, 0,0, 0);
    tbl[36] = mk(0,0,3'b011,3'b000, 3'b001,0,  0, 0,0, 0,0, 0);
    tbl[37] = mk(0,0,3'b000,3'b000, 3'b000,1, 10,20,1, 0,0, 0);

    tick();
    for (int v = 0; v < NV; v++) begin
      reset = tbl[v].rst; hold = tbl[v].hld; req = tbl[v].rq; lock = tbl[v].lk;
      #3;
      chk($sformatf("vec%0d gnt/plot/x/y/c/locked/owner/count", v),
          64'({gnt, vga_plot, vga_x, vga_y, vga_colour, locked, owner, pix_count}),
          64'({tbl[v].e_gnt, tbl[v].e_plot, tbl[v].e_x, tbl[v].e_y, tbl[v].e_c,
               tbl[v].e_lk, tbl[v].e_own, tbl[v].e_cnt}));
      tick();
    end

    // Dropped req[0] is skipped: 1 and 2 alternate.
    hold = 1'b0; lock = '0; req = 3'b110;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk($sformatf("skip_rr%0d gnt", c), 64'(gnt), (c % 2 == 0) ? 64'h2 : 64'h4);
      tick();
    end

    // Long sustained run drives the counter into saturation.
    req = 3'b111;
    for (int c = 0; c < 40; c++) tick();
    req = 3'b000;
    tick();
    tick();
    chk("pix_count saturated", 64'(pix_count), 64'h1F);

`ifdef PLOT_ARB_BOUNDS_EN
    reset = 1'b1; #3; reset = 1'b0; tick();
    req_x[7:0] = 8'd170; req_y[6:0] = 7'd50; req = 3'b001;
    #3;
    chk("bounds off-screen gnt", 64'(gnt), 64'h1);
    tick();
    req = 3'b000;
    #3;
    chk("bounds off-screen plot/drop/count", 64'({vga_plot, drop_count, pix_count}),
        64'({1'b0, 8'd1, 5'd0}));
    tick();
    req_x[7:0] = 8'd159; req_y[6:0] = 7'd119; req = 3'b001;
    #3;
    chk("bounds edge gnt", 64'(gnt), 64'h2 >> 1);
    tick();
    req = 3'b000;
    #3;
    chk("bounds edge plotted", 64'({vga_plot, vga_x, vga_y, drop_count}),
        64'({1'b1, 8'd159, 7'd119, 8'd1}));
    tick();
    #3;
    chk("bounds edge counted", 64'(pix_count), 64'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
